// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the architectural PC, issues one imem request at a time,
// buffers the returned instruction for decode and applies execute redirects.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [2:0]  npc_op,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_imm,
    output logic [31:0] pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    logic        redir;
    logic [31:0] redir_target;

    assign redir        = redirect_valid && (state_q != S_IDLE);
    assign redir_target = ((npc_op == NPC_BRANCH) || (npc_op == NPC_JUMP))
                          ? (redirect_base + redirect_imm)
                          : (redirect_base + 32'd4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    // The old-address request is already issued; its response must be dropped.
                    req_pc_d  = pc_q;
                    state_d   = S_WAIT;
                    discard_d = redir;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q || redir) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        inst_d       = imem_rsp_data;
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redir) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides any sequential PC advance, including a same-cycle consume.
        if (redir) begin
            pc_d = redir_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            discard_q    <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: an imem responder with programmable latency, an
// architectural-PC model checked every cycle, and literal checks per scenario.
module tb_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic [31:0] redirect_base = 32'h0;
    logic [31:0] redirect_imm = 32'h0;
    logic [31:0] pc;

    fetch_seq #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .npc_op         (npc_op),
        .redirect_base  (redirect_base),
        .redirect_imm   (redirect_imm),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + 32'h0101_0000;
    endfunction

    // Model state: architectural PC and consumption log
    logic [31:0] model_pc = RESET_PC;
    int          cyc_since = 0;
    int          cycle_no = 0;
    bit          expect_flush = 1'b0;
    bit          idle_cyc;
    bit          redir_m;
    bit          hs_seen = 1'b0;
    logic [31:0] hs_addr = 32'h0;
    logic [31:0] consumed[$];
    int          consume_cyc[$];

    // Compare then advance the model to what the next rising edge must produce
    initial forever begin
        @(negedge clk);
        cycle_no++;
        if (!rstn) begin
            chk32("rst_pc", pc, RESET_PC);
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk1("rst_inst_valid", inst_valid, 1'b0);
            chk32("rst_inst", inst, 32'h0);
            chk32("rst_inst_pc", inst_pc, 32'h0);
            model_pc     = RESET_PC;
            cyc_since    = 0;
            expect_flush = 1'b0;
            hs_seen      = 1'b0;
        end else begin
            idle_cyc = (cyc_since == 0);
            chk32("pc", pc, model_pc);
            if (idle_cyc) chk1("idle_req_valid", imem_req_valid, 1'b0);
            if (imem_req_valid) chk32("imem_addr", imem_addr, model_pc);
            if (inst_valid) begin
                chk32("inst_pc", inst_pc, model_pc);
                chk32("inst_data", inst, mem_word(inst_pc));
            end
            if (expect_flush) chk1("flush_inst_valid", inst_valid, 1'b0);
            hs_seen      = imem_req_valid && imem_req_ready;
            hs_addr      = imem_addr;
            redir_m      = redirect_valid && !idle_cyc;
            expect_flush = 1'b0;
            if (redir_m) begin
                model_pc     = ((npc_op == 3'b001) || (npc_op == 3'b010))
                               ? redirect_base + redirect_imm : redirect_base + 32'd4;
                expect_flush = 1'b1;
            end else if (inst_valid && inst_ready) begin
                consumed.push_back(inst_pc);
                consume_cyc.push_back(cycle_no);
                model_pc     = model_pc + 32'd4;
                expect_flush = 1'b1;
            end
            cyc_since++;
        end
    end

    // Instruction memory: response resp_lat cycles after each accepted request
    int          resp_lat = 1;
    int          rsp_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    initial forever begin
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hBAD0_BAD0;
        if (hs_seen) begin
            rsp_cnt   = resp_lat;
            pend_addr = hs_addr;
        end
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input string name);
        int n = 0;
        while (!inst_valid && n < 40) begin
            step();
            n++;
        end
        chk1({name, "_wait_inst"}, inst_valid, 1'b1);
    endtask

    task automatic wait_req_dropping(input string name);
        int n = 0;
        while (!imem_req_valid && n < 40) begin
            chk1({name, "_no_inst"}, inst_valid, 1'b0);
            step();
            n++;
        end
        chk1({name, "_wait_req"}, imem_req_valid, 1'b1);
    endtask

    task automatic redirect(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm);
        redirect_valid = 1'b1;
        npc_op         = op;
        redirect_base  = base;
        redirect_imm   = imm;
        step();
        redirect_valid = 1'b0;
        npc_op         = 3'b000;
    endtask

    initial begin
        int n;
        // Reset, then zero-wait fetch of 0x0, 0x4, 0x8 back to back
        inst_ready = 1'b1;
        step();
        step();
        chk32("t0_reset_pc", pc, RESET_PC);
        rstn = 1'b1;
        #1;
        chk1("t0_idle_no_req", imem_req_valid, 1'b0);
        n = 0;
        while (consumed.size() < 3 && n < 40) begin
            step();
            n++;
        end
        inst_ready = 1'b0;
        chk32("t1_consumed_count", 32'(consumed.size()), 32'd3);
        if (consumed.size() >= 3) begin
            chk32("t1_addr0", consumed[0], 32'h0);
            chk32("t1_addr1", consumed[1], 32'h4);
            chk32("t1_addr2", consumed[2], 32'h8);
            chk32("t1_gap01", 32'(consume_cyc[1] - consume_cyc[0]), 32'd3);
            chk32("t1_gap12", 32'(consume_cyc[2] - consume_cyc[1]), 32'd3);
        end
        $display("t1: fetched %0d instructions from reset", consumed.size());

        // Redirect while holding: BRANCH 0x8 + (-8) -> 0x0
        wait_inst("t2");
        chk32("t2_held_pc", inst_pc, 32'hC);
        redirect(3'b001, 32'h8, 32'hFFFF_FFF8);
        chk1("t2_flush", inst_valid, 1'b0);
        chk1("t2_req_valid", imem_req_valid, 1'b1);
        chk32("t2_req_addr", imem_addr, 32'h0);
        $display("t2: hold redirect -> imem_addr %h", imem_addr);

        // Redirect while waiting on a 3-cycle imem: JUMP 0x10 + 0x100
        resp_lat = 3;
        wait_inst("t3a");
        chk32("t3_held_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk32("t3_req_addr4", imem_addr, 32'h4);
        step();
        chk1("t3_in_wait", imem_req_valid, 1'b0);
        redirect(3'b010, 32'h10, 32'h100);
        wait_req_dropping("t3");
        chk32("t3_next_addr", imem_addr, 32'h110);
        wait_inst("t3b");
        chk32("t3_inst_pc", inst_pc, 32'h110);
        $display("t3: wait redirect -> refetch %h", inst_pc);

        // Redirect coincident with the handshake at 0x20 -> 0x40
        imem_req_ready = 1'b0;
        redirect(3'b010, 32'h20, 32'h0);
        chk1("t4_req_valid", imem_req_valid, 1'b1);
        chk32("t4_req_addr", imem_addr, 32'h20);
        imem_req_ready = 1'b1;
        redirect(3'b001, 32'h20, 32'h20);
        wait_req_dropping("t4");
        chk32("t4_next_addr", imem_addr, 32'h40);
        wait_inst("t4b");
        chk32("t4_inst_pc", inst_pc, 32'h40);
        chk32("t4_inst", inst, mem_word(32'h40));
        $display("t4: handshake redirect -> refetch %h", inst_pc);

        // Redirect with simultaneous consume, npc_op 3'b111 falls back to base+4
        inst_ready = 1'b1;
        redirect(3'b111, 32'h30, 32'h1234);
        inst_ready = 1'b0;
        chk32("t5_pc", pc, 32'h34);
        chk1("t5_flush", inst_valid, 1'b0);
        $display("t5: consume+redirect -> pc %h", pc);

        // Wrap-around, then asynchronous reset while a fetch is outstanding
        wait_inst("t6a");
        chk32("t6_held_pc", inst_pc, 32'h34);
        redirect(3'b000, 32'hFFFF_FFFC, 32'h55);
        chk32("t6_wrap_pc", pc, 32'h0);
        wait_inst("t6b");
        chk32("t6_wrap_inst_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        step();
        chk1("t6_in_wait", imem_req_valid, 1'b0);
        chk32("t6_pc_before_rst", pc, 32'h4);
        #1;
        rstn = 1'b0;
        #1;
        chk32("t6_async_rst_pc", pc, RESET_PC);
        chk1("t6_async_rst_req", imem_req_valid, 1'b0);
        chk1("t6_async_rst_inst", inst_valid, 1'b0);
        step();
        step();
        step();
        rstn = 1'b1;
        resp_lat = 1;
        wait_inst("t6c");
        chk32("t6_after_rst_inst_pc", inst_pc, RESET_PC);
        $display("t6: wrap then reset -> refetch %h", inst_pc);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
